cpu_run_mem: RTL

Memory-and-run-control responder on the far side of the CPU's instruction/data interface: serves instruction fetches and data loads/stores, and sequences the CPU through reset/enable/start. A host preloads program and data words while the CPU is idle. Detects HALT fetch or timeout, then returns memory to host access. Replaces hand-driven i_datain/d_datain stimulus in CPU-level benches and sits beside CPU at top level.

---
 rtl/cpu_run_mem.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cpu_run_mem.sv
// cpu_run_mem: memory and run-control responder for the CPU's instruction and
// data interface. It holds a 256x16 instruction memory and a 256x16 data memory.
// The host preloads both memories while the CPU is idle. The block then steps
// the CPU through reset, enable and start, and serves fetches, loads and stores
// during the run. It detects a HALT fetch or a timeout, then returns the
// memories to the host.
//
// Ports
//   clock, reset         system clock; asynchronous active-low reset
//   go, abort            start-run request; force return to IDLE
//   host_we/sel/addr/wdata/rdata
//                        host access (sel 0 = imem, 1 = dmem); rdata is combinational
//   host_busy            high while the CPU owns the memories; host writes dropped
//   i_addr, i_datain     CPU fetch port (NOP outside RUN)
//   d_addr, d_dataout, d_we, d_datain
//                        CPU load/store port
//   cpu_reset, cpu_enable, cpu_start
//                        CPU sequencing outputs
//   done, timeout, cycles
//                        run status and RUN-cycle count
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | host owns memories, CPU disabled
// CRST   | one cycle of cpu_reset low, cycle counter cleared
// CEN    | one cycle with cpu_enable high before start
// CSTART | cpu_start pulse, cpu_enable high
// RUN    | CPU executing; fetch/load/store served, cycles counting
// DONE   | HALT fetched; CPU disabled, done held
// TOUT   | run hit TIMEOUT cycles; CPU disabled, timeout held
module cpu_run_mem #(
  parameter logic [4:0]  HALT_OP = 5'b00001,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic        abort,
  input  logic        host_we,
  input  logic        host_sel,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        host_busy,
  input  logic [7:0]  i_addr,
  output logic [15:0] i_datain,
  input  logic [7:0]  d_addr,
  input  logic [15:0] d_dataout,
  input  logic        d_we,
  output logic [15:0] d_datain,
  output logic        cpu_reset,
  output logic        cpu_enable,
  output logic        cpu_start,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycles
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CRST   = 3'd1,
    CEN    = 3'd2,
    CSTART = 3'd3,
    RUN    = 3'd4,
    DONE   = 3'd5,
    TOUT   = 3'd6
  } state_t;

  localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

  state_t state, state_nxt;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];

  logic [15:0] fetch_word;
  logic        halt_hit;
  logic        tout_hit;
  logic        in_run;

  assign in_run     = (state == RUN);
  assign fetch_word = imem[i_addr];
  assign halt_hit   = (fetch_word[15:11] == HALT_OP);
  assign tout_hit   = (TIMEOUT != 16'd0) && (cycles == TO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, TOUT: if (go) state_nxt = CRST;
      CRST:             state_nxt = CEN;
      CEN:              state_nxt = CSTART;
      CSTART:           state_nxt = RUN;
      RUN: begin
        // HALT takes precedence over a timeout in the same cycle
        if (halt_hit)      state_nxt = DONE;
        else if (tout_hit) state_nxt = TOUT;
      end
      default:          state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // CRST always lasts one cycle, so heading into CRST is always an entry.
  // An abort freezes the count so the host can read how far the run got.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                cycles <= 16'd0;
    else if (abort)                            cycles <= cycles;
    else if (state_nxt == CRST)                cycles <= 16'd0;
    else if (in_run && (cycles != 16'hFFFF))   cycles <= cycles + 16'd1;
  end

  // Host writes and CPU stores never overlap: the host is locked out for the
  // whole CRST..RUN window. Memories are deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (host_we && !host_busy) begin
      if (host_sel) dmem[host_addr] <= host_wdata;
      else          imem[host_addr] <= host_wdata;
    end
    if (d_we && in_run) dmem[d_addr] <= d_dataout;
  end

  assign host_rdata = host_sel ? dmem[host_addr] : imem[host_addr];
  assign host_busy  = (state == CRST) || (state == CEN) || (state == CSTART) || in_run;
  assign i_datain   = in_run ? fetch_word : 16'h0000;
  assign d_datain   = dmem[d_addr];

  // Gating with reset keeps the CPU held in reset while this block is in reset
  assign cpu_reset  = reset && (state != CRST);
  assign cpu_enable = (state == CEN) || (state == CSTART) || in_run;
  assign cpu_start  = (state == CSTART);
  assign done       = (state == DONE);
  assign timeout    = (state == TOUT);

endmodule
